// File: rtl/eros_obi_bank_xbar.sv
// -----------------------------------------------------------------------------
// eros_obi_bank_xbar
//
// Purpose:
//   Crossbar between NMASTERS OBI masters and N_BANKS single-cycle RAM banks.
//   Each master address is decoded to a bank and a bank-local byte offset.
//   Banks are laid out either contiguously or word-interleaved. A round-robin
//   arbiter per bank grants one master per cycle, combinationally. Responses
//   come back exactly one cycle later and are routed to the granted master.
//
//   A request that falls outside the banked window, or that targets a gated
//   bank, is completed locally. The xbar grants it at once, drops any write
//   data, and returns ERR_RDATA in the next cycle with a one-cycle err_o pulse.
//
// Ports:
//   clk_i           sole clock, rising edge
//   rst_i           synchronous active-high reset
//   master_req_i    per-master OBI request (req, we, be, addr, wdata)
//   master_resp_o   per-master OBI response (gnt, rvalid, rdata)
//   ram_req_o       per-bank request; addr is the bank-local byte offset
//   ram_resp_i      per-bank response, rvalid one cycle after req (gnt ignored)
//   bank_en_i       per-bank enable; 0 = bank is power-gated
//   conflict_cnt_o  saturating count of lost-arbitration master-cycles
//   err_o           pulses in any cycle that carries an error response
// -----------------------------------------------------------------------------

package eros_obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module eros_obi_bank_xbar
    import eros_obi_pkg::*;
#(
    parameter int unsigned NMASTERS    = 6,
    parameter int unsigned N_BANKS     = 2,
    parameter int unsigned BANK_SIZE   = 32768,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned INTERLEAVED = 0,
    parameter logic [31:0] ERR_RDATA   = 32'hBADC_AB1E
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  obi_req_t            master_req_i   [NMASTERS],
    output obi_resp_t           master_resp_o  [NMASTERS],
    output obi_req_t            ram_req_o      [N_BANKS],
    input  obi_resp_t           ram_resp_i     [N_BANKS],
    input  logic [N_BANKS-1:0]  bank_en_i,
    output logic [31:0]         conflict_cnt_o,
    output logic                err_o
);

    localparam int unsigned LOG2_NB = $clog2(N_BANKS);
    localparam int unsigned LOG2_BS = $clog2(BANK_SIZE);
    localparam int unsigned BW      = (N_BANKS > 1)  ? LOG2_NB : 1;
    localparam int unsigned MW      = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    // The window can reach 2^32 bytes, so compare in 64 bits.
    localparam logic [63:0] SPAN    = 64'(N_BANKS) * 64'(BANK_SIZE);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [MW-1:0]        r_rr_ptr   [N_BANKS];
    logic [N_BANKS-1:0]   r_bank_vld;
    logic [MW-1:0]        r_bank_mst [N_BANKS];
    logic [NMASTERS-1:0]  r_err_pend;
    logic [31:0]          r_conflict_cnt;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]          w_off      [NMASTERS];
    logic [BW-1:0]        w_bank     [NMASTERS];
    logic [31:0]          w_local    [NMASTERS];
    logic [NMASTERS-1:0]  w_tgt_vld;   // request to a usable bank
    logic [NMASTERS-1:0]  w_err_req;   // request completed locally as an error

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path can leave it unassigned and infer a latch.
        w_tgt_vld = '0;
        w_err_req = '0;
        for (int m = 0; m < NMASTERS; m++) begin
            // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
            w_off[m] = master_req_i[m].addr - BASE_ADDR;
            if (N_BANKS == 1) begin
                w_bank[m]  = '0;
                w_local[m] = w_off[m] & 32'(BANK_SIZE - 1);
            end else if (INTERLEAVED != 0) begin
                w_bank[m]  = BW'(w_off[m] >> 2);
                w_local[m] = ((w_off[m] >> (2 + LOG2_NB)) << 2) | {30'b0, w_off[m][1:0]};
            end else begin
                w_bank[m]  = BW'(w_off[m] >> LOG2_BS);
                w_local[m] = w_off[m] & 32'(BANK_SIZE - 1);
            end
            if (master_req_i[m].req) begin
                if ((64'(w_off[m]) < SPAN) && bank_en_i[w_bank[m]]) begin
                    w_tgt_vld[m] = 1'b1;
                end else begin
                    w_err_req[m] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-bank round-robin arbitration, starting the search at the pointer
    // ------------------------------------------------------------------
    logic [N_BANKS-1:0]   w_bank_gnt;
    logic [MW-1:0]        w_bank_idx [N_BANKS];
    logic [NMASTERS-1:0]  w_mst_gnt;

    always_comb begin
        logic [MW-1:0] cand;
        cand       = '0;
        w_bank_gnt = '0;
        w_mst_gnt  = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            w_bank_idx[b] = '0;
            for (int unsigned i = 0; i < NMASTERS; i++) begin
                cand = MW'((32'(r_rr_ptr[b]) + i) % NMASTERS);
                if (!w_bank_gnt[b] && w_tgt_vld[cand] && (w_bank[cand] == BW'(b))) begin
                    w_bank_gnt[b] = 1'b1;
                    w_bank_idx[b] = cand;
                end
            end
            if (w_bank_gnt[b]) begin
                w_mst_gnt[w_bank_idx[b]] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Conflict counter: valid targets that did not win this cycle
    // ------------------------------------------------------------------
    logic [4:0]  w_conflicts;
    logic [32:0] w_cnt_sum;
    logic [31:0] w_cnt_next;

    always_comb begin
        w_conflicts = '0;
        for (int m = 0; m < NMASTERS; m++) begin
            w_conflicts = w_conflicts + 5'(w_tgt_vld[m] & ~w_mst_gnt[m]);
        end
        w_cnt_sum  = {1'b0, r_conflict_cnt} + 33'(w_conflicts);
        w_cnt_next = w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples the pre-edge values, whatever the statement order.
        if (rst_i) begin
            // NOTE: all state here is small control flops and is reset.
            // There is no storage array in this block.
            for (int b = 0; b < N_BANKS; b++) begin
                r_rr_ptr[b]   <= '0;
                r_bank_mst[b] <= '0;
            end
            r_bank_vld     <= '0;
            r_err_pend     <= '0;
            r_conflict_cnt <= '0;
        end else begin
            for (int b = 0; b < N_BANKS; b++) begin
                if (w_bank_gnt[b]) begin
                    r_bank_mst[b] <= w_bank_idx[b];
                    r_rr_ptr[b]   <= (32'(w_bank_idx[b]) == NMASTERS - 1) ? '0
                                                                          : w_bank_idx[b] + MW'(1);
                end
            end
            r_bank_vld     <= w_bank_gnt;
            r_err_pend     <= w_err_req;
            r_conflict_cnt <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Bank request mux
    // ------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < N_BANKS; b++) begin
            ram_req_o[b] = '0;
            if (!rst_i && w_bank_gnt[b]) begin
                ram_req_o[b].req   = 1'b1;
                ram_req_o[b].we    = master_req_i[w_bank_idx[b]].we;
                ram_req_o[b].be    = master_req_i[w_bank_idx[b]].be;
                ram_req_o[b].addr  = w_local[w_bank_idx[b]];
                ram_req_o[b].wdata = master_req_i[w_bank_idx[b]].wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Master responses. One grant per master per cycle means at most one
    // source (a bank or the local error path) drives any master's rvalid.
    // ------------------------------------------------------------------
    always_comb begin
        for (int m = 0; m < NMASTERS; m++) begin
            master_resp_o[m] = '0;
        end
        err_o = 1'b0;
        if (!rst_i) begin
            for (int m = 0; m < NMASTERS; m++) begin
                master_resp_o[m].gnt = w_mst_gnt[m] | w_err_req[m];
                if (r_err_pend[m]) begin
                    master_resp_o[m].rvalid = 1'b1;
                    master_resp_o[m].rdata  = ERR_RDATA;
                end
            end
            for (int b = 0; b < N_BANKS; b++) begin
                if (r_bank_vld[b] && ram_resp_i[b].rvalid) begin
                    master_resp_o[r_bank_mst[b]].rvalid = 1'b1;
                    master_resp_o[r_bank_mst[b]].rdata  = ram_resp_i[b].rdata;
                end
            end
            err_o = |r_err_pend;
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;

    // Bank grant is assumed always high, so the returned gnt is deliberately unused.
    logic [N_BANKS-1:0] w_unused_gnt;
    always_comb begin
        for (int b = 0; b < N_BANKS; b++) begin
            w_unused_gnt[b] = ram_resp_i[b].gnt;
        end
    end

endmodule

// File: tb/tb_eros_obi_bank_xbar.sv
// -----------------------------------------------------------------------------
// tb_eros_obi_bank_xbar
//
// Drives two crossbars from the same master stimulus: one contiguous and one
// word-interleaved. Each bank is a one-cycle RAM whose read data is a fixed
// function of bank and local address. A reference model computes the expected
// grants, bank requests, responses, err_o and counter from the address map and
// round-robin rules.
// -----------------------------------------------------------------------------
module tb_eros_obi_bank_xbar;
    import eros_obi_pkg::*;

    localparam int          NM   = 6;
    localparam int          NB   = 2;
    localparam int          BS   = 32768;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] ERRD = 32'hBADC_AB1E;

    logic            clk = 1'b0;
    logic            rst;
    obi_req_t        mreq    [NM];
    logic [NB-1:0]   bank_en;
    obi_resp_t       mresp_c [NM];
    obi_resp_t       mresp_i [NM];
    obi_req_t        rreq_c  [NB];
    obi_req_t        rreq_i  [NB];
    obi_resp_t       rresp_c [NB];
    obi_resp_t       rresp_i [NB];
    logic [31:0]     cnt_c, cnt_i;
    logic            err_c, err_i;

    int checks = 0;
    int errors = 0;

    // Reference model state, indexed by DUT (0 contiguous, 1 interleaved)
    int          ptr     [2][NB];
    bit          exp_rv  [2][NM];
    logic [31:0] exp_rd  [2][NM];
    bit          exp_err [2];
    logic [31:0] exp_cnt [2];

    always #5 clk = ~clk;

    eros_obi_bank_xbar #(
        .NMASTERS(NM), .N_BANKS(NB), .BANK_SIZE(BS), .BASE_ADDR(BASE),
        .INTERLEAVED(0), .ERR_RDATA(ERRD)
    ) u_dut_c (
        .clk_i(clk), .rst_i(rst), .master_req_i(mreq), .master_resp_o(mresp_c),
        .ram_req_o(rreq_c), .ram_resp_i(rresp_c), .bank_en_i(bank_en),
        .conflict_cnt_o(cnt_c), .err_o(err_c)
    );

    eros_obi_bank_xbar #(
        .NMASTERS(NM), .N_BANKS(NB), .BANK_SIZE(BS), .BASE_ADDR(BASE),
        .INTERLEAVED(1), .ERR_RDATA(ERRD)
    ) u_dut_i (
        .clk_i(clk), .rst_i(rst), .master_req_i(mreq), .master_resp_o(mresp_i),
        .ram_req_o(rreq_i), .ram_resp_i(rresp_i), .bank_en_i(bank_en),
        .conflict_cnt_o(cnt_i), .err_o(err_i)
    );

    function automatic logic [31:0] bank_data(input int b, input logic [31:0] a);
        return 32'hB0A0_0000 ^ (32'(b) << 24) ^ a;
    endfunction

    // One-cycle RAM banks
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            rresp_c[b].gnt    <= 1'b1;
            rresp_c[b].rvalid <= rreq_c[b].req;
            rresp_c[b].rdata  <= bank_data(b, rreq_c[b].addr);
            rresp_i[b].gnt    <= 1'b1;
            rresp_i[b].rvalid <= rreq_i[b].req;
            rresp_i[b].rdata  <= bank_data(b, rreq_i[b].addr);
        end
    end

    function automatic obi_resp_t resp_of(input int k, input int m);
        return (k == 0) ? mresp_c[m] : mresp_i[m];
    endfunction
    function automatic obi_req_t rreq_of(input int k, input int b);
        return (k == 0) ? rreq_c[b] : rreq_i[b];
    endfunction
    function automatic logic [31:0] cnt_of(input int k);
        return (k == 0) ? cnt_c : cnt_i;
    endfunction
    function automatic logic erro_of(input int k);
        return (k == 0) ? err_c : err_i;
    endfunction

    task automatic clear_reqs();
        for (int m = 0; m < NM; m++) mreq[m] = '0;
    endtask

    task automatic set_req(input int m, input bit we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
        mreq[m].req   = 1'b1;
        mreq[m].we    = we;
        mreq[m].addr  = addr;
        mreq[m].be    = be;
        mreq[m].wdata = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples both DUTs at the falling edge, compares them with the model,
    // then advances the model to the next cycle.
    task automatic eval_cycle();
        #4;
        for (int k = 0; k < 2; k++) begin
            bit          vt   [NM];
            bit          er   [NM];
            int          bk   [NM];
            logic [31:0] loc  [NM];
            int          win  [NB];
            logic [31:0] off;
            logic [63:0] sum;
            bit          inr, en, ge;
            int          best, d, confl;
            obi_resp_t   rs;
            obi_req_t    rq;

            for (int m = 0; m < NM; m++) begin
                off = mreq[m].addr - BASE;
                inr = ({32'b0, off} < 64'(NB * BS));
                if (k == 0) begin
                    bk[m]  = int'(off / BS);
                    loc[m] = off % BS;
                end else begin
                    bk[m]  = int'((off / 4) % NB);
                    loc[m] = (off / (4 * NB)) * 4 + (off % 4);
                end
                en    = inr ? bank_en[bk[m]] : 1'b0;
                vt[m] = mreq[m].req && inr && en;
                er[m] = mreq[m].req && !(inr && en);
            end

            if (rst) begin
                for (int m = 0; m < NM; m++) begin
                    rs = resp_of(k, m);
                    checks++;
                    if (rs !== '0) begin
                        errors++;
                        $display("FAIL rst_resp dut%0d m%0d got %h exp 0", k, m, rs);
                    end
                end
                for (int b = 0; b < NB; b++) begin
                    rq = rreq_of(k, b);
                    checks++;
                    if (rq.req !== 1'b0) begin
                        errors++;
                        $display("FAIL rst_ram_req dut%0d b%0d got %b exp 0", k, b, rq.req);
                    end
                end
                checks++;
                if (erro_of(k) !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_err dut%0d got %b exp 0", k, erro_of(k));
                end
                for (int b = 0; b < NB; b++) ptr[k][b] = 0;
                for (int m = 0; m < NM; m++) exp_rv[k][m] = 1'b0;
                exp_err[k] = 1'b0;
                exp_cnt[k] = '0;
            end else begin
                // Winner per bank: the candidate closest to the pointer going upwards.
                for (int b = 0; b < NB; b++) begin
                    win[b] = -1;
                    best   = NM;
                    for (int m = 0; m < NM; m++) begin
                        if (vt[m] && bk[m] == b) begin
                            d = (m - ptr[k][b] + NM) % NM;
                            if (d < best) begin
                                best   = d;
                                win[b] = m;
                            end
                        end
                    end
                end

                confl = 0;
                for (int m = 0; m < NM; m++) begin
                    ge = er[m] || (vt[m] && win[bk[m]] == m);
                    if (vt[m] && !ge) confl++;
                    rs = resp_of(k, m);
                    checks++;
                    if (rs.gnt !== ge) begin
                        errors++;
                        $display("FAIL gnt dut%0d m%0d got %b exp %b", k, m, rs.gnt, ge);
                    end
                    checks++;
                    if (rs.rvalid !== exp_rv[k][m]) begin
                        errors++;
                        $display("FAIL rvalid dut%0d m%0d got %b exp %b", k, m, rs.rvalid, exp_rv[k][m]);
                    end
                    if (exp_rv[k][m]) begin
                        checks++;
                        if (rs.rdata !== exp_rd[k][m]) begin
                            errors++;
                            $display("FAIL rdata dut%0d m%0d got %h exp %h", k, m, rs.rdata, exp_rd[k][m]);
                        end
                    end
                end
                checks++;
                if (erro_of(k) !== exp_err[k]) begin
                    errors++;
                    $display("FAIL err_o dut%0d got %b exp %b", k, erro_of(k), exp_err[k]);
                end
                checks++;
                if (cnt_of(k) !== exp_cnt[k]) begin
                    errors++;
                    $display("FAIL conflict_cnt dut%0d got %0d exp %0d", k, cnt_of(k), exp_cnt[k]);
                end
                for (int b = 0; b < NB; b++) begin
                    rq = rreq_of(k, b);
                    checks++;
                    if (rq.req !== (win[b] >= 0)) begin
                        errors++;
                        $display("FAIL ram_req dut%0d b%0d got %b exp %b", k, b, rq.req, win[b] >= 0);
                    end else if (win[b] >= 0) begin
                        checks++;
                        if ({rq.addr, rq.we, rq.be, rq.wdata} !==
                            {loc[win[b]], mreq[win[b]].we, mreq[win[b]].be, mreq[win[b]].wdata}) begin
                            errors++;
                            $display("FAIL ram_fields dut%0d b%0d got %h/%b/%h/%h exp %h/%b/%h/%h",
                                     k, b, rq.addr, rq.we, rq.be, rq.wdata, loc[win[b]],
                                     mreq[win[b]].we, mreq[win[b]].be, mreq[win[b]].wdata);
                        end
                    end
                end

                // Advance the model
                for (int m = 0; m < NM; m++) begin
                    exp_rv[k][m] = er[m];
                    exp_rd[k][m] = ERRD;
                end
                exp_err[k] = 1'b0;
                for (int m = 0; m < NM; m++) if (er[m]) exp_err[k] = 1'b1;
                for (int b = 0; b < NB; b++) begin
                    if (win[b] >= 0) begin
                        exp_rv[k][win[b]] = 1'b1;
                        exp_rd[k][win[b]] = bank_data(b, loc[win[b]]);
                        ptr[k][b]         = (win[b] + 1) % NM;
                    end
                end
                sum        = {32'b0, exp_cnt[k]} + 64'(confl);
                exp_cnt[k] = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
            end
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bank_en = 2'b11;
        clear_reqs();
        eval_cycle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bank_en = 2'b11;
        for (int c = 0; c < 2; c++) begin
            for (int m = 0; m < NM; m++) set_req(m, 1'b0, $urandom_range(0, 65535), 4'hF, $urandom);
            eval_cycle();
            if (c == 1) begin
                checks++;
                if (cnt_c !== 32'd0 || cnt_i !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_cnt got %0d/%0d exp 0", cnt_c, cnt_i);
                end
            end
            tick();
        end
        rst = 1'b0;
        clear_reqs();
    endtask

    task automatic test_contig_read();
        set_req(0, 1'b0, 32'h0000_8004, 4'hF, 32'h0);
        eval_cycle();
        checks++;
        if (rreq_c[1].req !== 1'b1 || rreq_c[1].addr !== 32'h0000_0004) begin
            errors++;
            $display("FAIL contig_addr got %b/%h exp 1/00000004", rreq_c[1].req, rreq_c[1].addr);
        end
        tick();
        clear_reqs();
        eval_cycle();
        checks++;
        if (mresp_c[0].rvalid !== 1'b1 || mresp_c[0].rdata !== bank_data(1, 32'h4)) begin
            errors++;
            $display("FAIL contig_resp got %b/%h exp 1/%h", mresp_c[0].rvalid, mresp_c[0].rdata,
                     bank_data(1, 32'h4));
        end
        tick();
    endtask

    task automatic test_interleaved_write();
        logic [31:0] wd;
        wd = $urandom;
        set_req(2, 1'b1, 32'h0000_000C, 4'b0110, wd);
        eval_cycle();
        checks++;
        if ({rreq_i[1].req, rreq_i[1].we, rreq_i[1].addr, rreq_i[1].be, rreq_i[1].wdata} !==
            {1'b1, 1'b1, 32'h0000_0004, 4'b0110, wd}) begin
            errors++;
            $display("FAIL ilv_write got %b/%b/%h/%b/%h exp 1/1/00000004/0110/%h", rreq_i[1].req,
                     rreq_i[1].we, rreq_i[1].addr, rreq_i[1].be, rreq_i[1].wdata, wd);
        end
        tick();
        clear_reqs();
        eval_cycle();
        checks++;
        if (mresp_i[2].rvalid !== 1'b1) begin
            errors++;
            $display("FAIL ilv_rvalid got %b exp 1", mresp_i[2].rvalid);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] masks [3];
        logic [NM-1:0] gnts  [3];
        logic [NM-1:0] g_c, g_i;
        masks[0] = 6'b001011; gnts[0] = 6'b000001;
        masks[1] = 6'b001010; gnts[1] = 6'b000010;
        masks[2] = 6'b001000; gnts[2] = 6'b001000;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            clear_reqs();
            for (int m = 0; m < NM; m++) if (masks[c][m]) set_req(m, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
            eval_cycle();
            for (int m = 0; m < NM; m++) begin
                g_c[m] = mresp_c[m].gnt;
                g_i[m] = mresp_i[m].gnt;
            end
            checks++;
            if (g_c !== gnts[c] || g_i !== gnts[c]) begin
                errors++;
                $display("FAIL rr_grant cycle%0d got %b/%b exp %b", c, g_c, g_i, gnts[c]);
            end
            tick();
        end
        clear_reqs();
        eval_cycle();
        checks++;
        if (cnt_c !== 32'd3 || cnt_i !== 32'd3) begin
            errors++;
            $display("FAIL rr_conflicts got %0d/%0d exp 3", cnt_c, cnt_i);
        end
        tick();
    endtask

    task automatic test_disabled_bank();
        bank_en = 2'b01;
        set_req(1, 1'b0, 32'h0000_8004, 4'hF, 32'h0);
        eval_cycle();
        checks++;
        if (mresp_c[1].gnt !== 1'b1 || mresp_i[1].gnt !== 1'b1 || rreq_c[1].req !== 1'b0 ||
            rreq_i[1].req !== 1'b0) begin
            errors++;
            $display("FAIL gated_gnt got %b%b%b%b exp 1100", mresp_c[1].gnt, mresp_i[1].gnt,
                     rreq_c[1].req, rreq_i[1].req);
        end
        tick();
        clear_reqs();
        eval_cycle();
        checks++;
        if (mresp_c[1].rvalid !== 1'b1 || mresp_c[1].rdata !== ERRD || mresp_i[1].rdata !== ERRD ||
            err_c !== 1'b1 || err_i !== 1'b1 || rreq_c[1].req !== 1'b0) begin
            errors++;
            $display("FAIL gated_resp got %b/%h/%h/%b%b exp 1/%h/%h/11", mresp_c[1].rvalid,
                     mresp_c[1].rdata, mresp_i[1].rdata, err_c, err_i, ERRD, ERRD);
        end
        tick();
        eval_cycle();
        checks++;
        if (err_c !== 1'b0 || err_i !== 1'b0) begin
            errors++;
            $display("FAIL gated_pulse got %b%b exp 00", err_c, err_i);
        end
        tick();
        bank_en = 2'b11;
    endtask

    task automatic test_out_of_range();
        do_reset();
        set_req(4, 1'b0, BASE + 32'(NB * BS), 4'hF, 32'h0);
        set_req(5, 1'b1, 32'hFFFF_FFF0, 4'hF, 32'h1234_5678);
        eval_cycle();
        checks++;
        if (rreq_c[0].req !== 1'b0 || rreq_c[1].req !== 1'b0 || rreq_i[0].req !== 1'b0 ||
            rreq_i[1].req !== 1'b0) begin
            errors++;
            $display("FAIL oor_ram_req got %b%b%b%b exp 0000", rreq_c[0].req, rreq_c[1].req,
                     rreq_i[0].req, rreq_i[1].req);
        end
        tick();
        clear_reqs();
        eval_cycle();
        checks++;
        if (mresp_c[4].rdata !== ERRD || mresp_i[5].rdata !== ERRD || err_c !== 1'b1 ||
            cnt_c !== 32'd0 || cnt_i !== 32'd0) begin
            errors++;
            $display("FAIL oor_resp got %h/%h/%b/%0d/%0d exp %h/%h/1/0/0", mresp_c[4].rdata,
                     mresp_i[5].rdata, err_c, cnt_c, cnt_i, ERRD, ERRD);
        end
        tick();
    endtask

    task automatic test_disable_inflight();
        set_req(0, 1'b0, 32'h0000_8014, 4'hF, 32'h0);
        eval_cycle();
        tick();
        bank_en = 2'b01;
        clear_reqs();
        set_req(1, 1'b0, 32'h0000_8014, 4'hF, 32'h0);
        eval_cycle();
        checks++;
        if (mresp_c[0].rdata !== bank_data(1, 32'h14) || mresp_i[0].rdata !== bank_data(1, 32'h4008) ||
            mresp_c[0].rvalid !== 1'b1 || mresp_i[1].gnt !== 1'b1 || rreq_c[1].req !== 1'b0) begin
            errors++;
            $display("FAIL inflight got %h/%h/%b/%b/%b exp %h/%h/1/1/0", mresp_c[0].rdata,
                     mresp_i[0].rdata, mresp_c[0].rvalid, mresp_i[1].gnt, rreq_c[1].req,
                     bank_data(1, 32'h14), bank_data(1, 32'h4008));
        end
        tick();
        clear_reqs();
        eval_cycle();
        tick();
        bank_en = 2'b11;
    endtask

    task automatic test_reset_inflight();
        logic [NM-1:0] g_c, rv_c;
        do_reset();
        set_req(0, 1'b0, 32'h0000_0000, 4'hF, 32'h0);
        set_req(1, 1'b0, 32'h0000_0000, 4'hF, 32'h0);
        eval_cycle();
        tick();
        rst = 1'b1;
        clear_reqs();
        eval_cycle();
        tick();
        rst = 1'b0;
        for (int m = 0; m < NM; m++) set_req(m, 1'b0, 32'h0000_0020, 4'hF, 32'h0);
        eval_cycle();
        for (int m = 0; m < NM; m++) begin
            g_c[m]  = mresp_c[m].gnt;
            rv_c[m] = mresp_c[m].rvalid | mresp_i[m].rvalid;
        end
        checks++;
        if (g_c !== 6'b000001 || rv_c !== 6'b0 || cnt_c !== 32'd0 || cnt_i !== 32'd0) begin
            errors++;
            $display("FAIL rst_inflight got %b/%b/%0d/%0d exp 000001/000000/0/0", g_c, rv_c, cnt_c, cnt_i);
        end
        tick();
        clear_reqs();
        eval_cycle();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 9))
                        0:       set_req(m, 1'($urandom), $urandom, 4'($urandom), $urandom);
                        1:       set_req(m, 1'($urandom), 32'h0001_0000 + $urandom_range(0, 63),
                                         4'($urandom), $urandom);
                        default: set_req(m, 1'($urandom), $urandom_range(0, 65535),
                                         4'($urandom), $urandom);
                    endcase
                end else begin
                    mreq[m] = '0;
                end
            end
            bank_en = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
            eval_cycle();
            tick();
        end
        clear_reqs();
        bank_en = 2'b11;
        eval_cycle();
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        bank_en = 2'b11;
        clear_reqs();
        @(posedge clk);
        #1;
        test_reset();
        test_contig_read();
        test_interleaved_write();
        test_round_robin();
        test_disabled_bank();
        test_out_of_range();
        test_disable_inflight();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eros_obi_bank_xbar.md
EROS_OBI_BANK_XBAR -- requirements
Module: eros_obi_bank_xbar

Interface
REQ-001 Parameter NMASTERS, default 6, number of OBI master ports (2*NHARTS instr+data); SHALL be 1..16.
REQ-002 Parameter N_BANKS, default 2, number of RAM banks; SHALL be a power of two, 1..16.
REQ-003 Parameter BANK_SIZE, default 32768, bytes per bank; SHALL be a power of two, at least 4*N_BANKS.
REQ-004 Parameter BASE_ADDR, default 32'h0000_0000, byte address of bank 0 word 0; SHALL be BANK_SIZE*N_BANKS aligned.
REQ-005 Parameter INTERLEAVED, default 0, mapping mode: 0 contiguous, 1 word-interleaved.
REQ-006 Parameter ERR_RDATA, default 32'hBADC_AB1E, read data returned on error responses.
REQ-007 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst_i  input  1  synchronous, active-high reset, sampled on clk_i rising edge.
REQ-009 master_req_i  input  obi_req_t[NMASTERS]  OBI requests (req, we, be, addr, wdata).
REQ-010 master_resp_o  output  obi_resp_t[NMASTERS]  OBI responses (gnt, rvalid, rdata).
REQ-011 ram_req_o  output  obi_req_t[N_BANKS]  bank requests; addr is bank-local byte offset.
REQ-012 ram_resp_i  input  obi_resp_t[N_BANKS]  bank responses; bank rvalid exactly 1 cycle after req.
REQ-013 bank_en_i  input  N_BANKS  1 = bank powered and usable; 0 = gated (pwrgate_ack).
REQ-014 conflict_cnt_o  output  32  saturating count of lost-arbitration master-cycles.
REQ-015 err_o  output  1  one-cycle pulse when any error response is issued.

Function
REQ-016 Decode: off = addr - BASE_ADDR; contiguous bank = off/BANK_SIZE, local = off mod BANK_SIZE; interleaved bank = off[2 +: log2(N_BANKS)], local = {off/(4*N_BANKS), off[1:0]}.
REQ-017 Out-of-range addr (off >= N_BANKS*BANK_SIZE, incl. below BASE_ADDR via wrap) or bank_en_i[bank]=0 SHALL be an error request.
REQ-018 Error request: gnt asserted same cycle combinationally, no ram_req_o issued, rvalid next cycle with rdata=ERR_RDATA, err_o pulses in that response cycle; writes discarded.
REQ-019 Per bank, one round-robin arbiter among masters targeting it; grant combinational in the request cycle.
REQ-020 RR pointer per bank resets to 0; on grant to master m, pointer becomes (m+1) mod NMASTERS; no grant, pointer holds.
REQ-021 Priority search starts at pointer, ascending with wrap; lowest index wins ties only relative to the pointer.
REQ-022 ram_req_o[b].req = 1 only for the granted master; other fields forwarded from it; bank gnt assumed always 1 (ram_resp_i.gnt ignored).
REQ-023 Registered per bank: valid bit + granted master index; next cycle routes ram_resp_i[b].rvalid/rdata to that master only.
REQ-024 A master may issue back-to-back requests, including a new request in its response cycle; fixed 1-cycle latency keeps responses in order; no outstanding limit.
REQ-025 At most one of bank response or error response targets a given master per cycle (guaranteed by one grant per master per cycle).
REQ-026 Ungranted master keeps gnt=0 and SHALL hold request stable (OBI); xbar does not check it.
REQ-027 conflict_cnt_o increments each cycle by the number of masters with req=1, valid non-error target, gnt=0; saturates at 32'hFFFF_FFFF.
REQ-028 bank_en_i falling while a grant is in flight: response of already-granted request still routed; new requests error from that cycle.
REQ-029 N_BANKS=1: bank index is constant 0; both modes reduce to identical mapping.

Reset
REQ-030 During rst_i=1: all master gnt=0, rvalid=0, rdata=0; all ram_req_o.req=0; err_o=0.
REQ-031 Reset clears RR pointers to 0, response-valid bits to 0, conflict_cnt_o to 0; in-flight responses discarded.
REQ-032 First grant possible in the first cycle with rst_i=0.

Verification
REQ-033 Contiguous, N_BANKS=2, BANK_SIZE=32768: master0 reads 0x8004 -> ram_req_o[1].addr=0x0004, master0 rvalid next cycle with bank1 rdata.
REQ-034 Interleaved, N_BANKS=2: master2 writes 0x000C -> ram_req_o[1] addr=0x0004, be/wdata forwarded, rvalid next cycle.
REQ-035 Masters 0,1,3 request bank0 every cycle for 3 cycles -> grants 0,1,3 in order; conflict_cnt_o = 2+1+0 = 3.
REQ-036 bank_en_i=2'b01, master1 reads bank1 -> gnt same cycle, rvalid next with 0xBADCAB1E, err_o one pulse, ram_req_o[1].req never 1.
REQ-037 Read to BASE_ADDR+N_BANKS*BANK_SIZE -> error response; conflict_cnt_o unchanged.
REQ-038 Assert rst_i in the cycle after a grant -> no rvalid delivered, counter 0, pointers 0 next cycle.
